delay_skew: RTL and testbench

- Parametrised multi-channel delay line that skews operand vectors for the systolic matrix-multiply array.
- Channel c is delayed by BASE_DELAY + c*STEP enabled cycles, producing the staircase wavefront the PE grid needs.
- Carries a valid bit per stage, stalls on en, flushes on command, and zeroes invalid outputs so downstream MACs accumulate nothing.
- Generalises the single-bit one-cycle delay register to N channels × W bits with per-channel depth.

---
 rtl/delay_skew_pkg.sv | 23 ++
 rtl/delay_skew_lane.sv | 54 +++++
 rtl/delay_skew.sv | 61 ++++++
 tb/tb_delay_skew.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/delay_skew_pkg.sv
// Shared constants and delay helpers for the operand skew/deskew delay lines.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package delay_skew_pkg;

  // Operand width used by the PE array; the skew block defaults to the same.
  localparam int PE_WIDTH = 8;

  // Delay in enabled cycles of lane c. Reverse mode mirrors the staircase so the
  // array output can be realigned.
  function automatic int lane_delay(int c, int base, int step, bit reverse, int channels);
    if (reverse) begin
      return base + (channels - 1 - c) * step;
    end
    return base + c * step;
  endfunction

  // Deepest lane; identical in forward and reverse mode.
  function automatic int max_delay(int channels, int base, int step);
    return base + (channels - 1) * step;
  endfunction

endpackage

// File: rtl/delay_skew_lane.sv
// Single lane: DEPTH-stage shift register of {valid, data}, zeroed output when invalid.
// Latency: DEPTH enabled cycles from in_* to out_*.
// Backpressure: en=0 freezes every stage; flush clears all stages (priority flush > en).
module delay_skew_lane #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             any_valid
);

  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][WIDTH-1:0] dat_q, dat_d;

  // Next state: flush clears, en shifts (data captured only with valid), otherwise hold.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush) begin
      vld_d = '0;
      dat_d = '0;
    end else if (en) begin
      vld_d[0] = in_valid;
      dat_d[0] = in_valid ? in_data : '0;
      for (int k = 1; k < DEPTH; k++) begin
        vld_d[k] = vld_q[k-1];
        dat_d[k] = dat_q[k-1];
      end
    end
  end

  // Stage registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : '0;
  assign any_valid = |vld_q;

endmodule

// File: rtl/delay_skew.sv
// Multi-lane skew delay line: lane c delayed by lane_delay(c) enabled cycles (staircase).
// Latency: BASE_DELAY + c*STEP enabled cycles (mirrored when DELAY_SKEW_REVERSE_EN is defined).
// Backpressure: en=0 stalls all lanes indefinitely; flush discards everything in flight.
module delay_skew
  import delay_skew_pkg::*;
#(
  parameter int WIDTH      = PE_WIDTH,
  parameter int CHANNELS   = 4,
  parameter int BASE_DELAY = 1,
  parameter int STEP       = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      flush,
  input  logic                      din_valid,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [CHANNELS-1:0]       dout_valid,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      busy
);

`ifdef DELAY_SKEW_REVERSE_EN
  localparam bit REVERSE = 1'b1;
`else
  localparam bit REVERSE = 1'b0;
`endif

  localparam int MAX_DELAY = max_delay(CHANNELS, BASE_DELAY, STEP);

  if (BASE_DELAY < 1) begin : g_bad_base
    $error("delay_skew: BASE_DELAY must be >= 1");
  end
  if (MAX_DELAY < BASE_DELAY) begin : g_bad_step
    $error("delay_skew: STEP must be >= 0");
  end

  logic [CHANNELS-1:0] lane_any;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    localparam int D = lane_delay(c, BASE_DELAY, STEP, REVERSE, CHANNELS);

    delay_skew_lane #(
      .WIDTH (WIDTH),
      .DEPTH (D)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .flush     (flush),
      .in_valid  (din_valid),
      .in_data   (din[c*WIDTH +: WIDTH]),
      .out_valid (dout_valid[c]),
      .out_data  (dout[c*WIDTH +: WIDTH]),
      .any_valid (lane_any[c])
    );
  end

  assign busy = |lane_any;

endmodule

// File: tb/tb_delay_skew.sv
// Bench for delay_skew: constant vector table, directed reset, then random traffic vs a history-queue model.
// Latency: n/a.
// Backpressure: en and flush randomised in the random phase.
module tb_delay_skew;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int BD = 1;
`ifdef DELAY_SKEW_REVERSE_EN
  localparam int ST = 2;
`else
  localparam int ST = 1;
`endif
  localparam int MAXD = BD + (CH - 1) * ST;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              en = 1'b0;
  logic              flush = 1'b0;
  logic              din_valid = 1'b0;
  logic [CH*W-1:0]   din = '0;
  logic [CH-1:0]     dout_valid;
  logic [CH*W-1:0]   dout;
  logic              busy;

  delay_skew #(.WIDTH(W), .CHANNELS(CH), .BASE_DELAY(BD), .STEP(ST)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .din_valid(din_valid),
    .din(din), .dout_valid(dout_valid), .dout(dout), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference: queue of accepted vectors, newest first; one entry per enabled edge.
  typedef struct packed { logic v; logic [CH*W-1:0] d; } tok_t;
  tok_t hist[$];
  int   dly[CH];

  typedef struct packed {
    logic            en, flush, v;
    logic [CH*W-1:0] din;
    logic [CH*W-1:0] exp_d;
    logic [CH-1:0]   exp_v;
    logic            exp_b;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [CH*W-1:0] act, input logic [CH*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_out(output logic [CH*W-1:0] ed, output logic [CH-1:0] ev, output logic eb);
    ed = '0; ev = '0; eb = 1'b0;
    for (int c = 0; c < CH; c++) begin
      if (hist.size() >= dly[c] && hist[dly[c]-1].v) begin
        ev[c] = 1'b1;
        ed[c*W +: W] = hist[dly[c]-1].d[c*W +: W];
      end
    end
    foreach (hist[i]) if (hist[i].v) eb = 1'b1;
  endfunction

  task automatic check_model(input string name);
    logic [CH*W-1:0] ed; logic [CH-1:0] ev; logic eb;
    model_out(ed, ev, eb);
    check({name, ".dout"}, dout, ed);
    check({name, ".valid"}, {{(CH*W-CH){1'b0}}, dout_valid}, {{(CH*W-CH){1'b0}}, ev});
    check({name, ".busy"}, {{(CH*W-1){1'b0}}, busy}, {{(CH*W-1){1'b0}}, eb});
  endtask

  // One clock edge: model follows the spec rules with the inputs held across the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset || flush) hist = {};
    else if (en) begin
      hist.push_front(tok_t'{din_valid, din});
      if (hist.size() > MAXD) void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic add(input logic e, input logic f, input logic v, input logic [CH*W-1:0] d,
                     input logic [CH*W-1:0] xd, input logic [CH-1:0] xv, input logic xb);
    tbl.push_back(vec_t'{e, f, v, d, xd, xv, xb});
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin
`ifdef DELAY_SKEW_REVERSE_EN
      dly[c] = BD + (CH - 1 - c) * ST;
`else
      dly[c] = BD + c * ST;
`endif
    end

    // ---- Reset held with live-looking input ----
    din = 32'hFFFF_FFFF; din_valid = 1'b1; en = 1'b1;
    #1;
    check("rst_now.dout", dout, '0);
    check("rst_now.valid", {28'd0, dout_valid}, '0);
    check("rst_now.busy", {31'd0, busy}, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_edge.dout", dout, '0);
      check("rst_edge.busy", {31'd0, busy}, '0);
    end
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < MAXD + 2; i++) begin
      tick();
      check_model("rst_release");
    end
    // Async assertion mid-cycle clears outputs without an edge.
    @(negedge clk); reset = 1'b0; hist = {}; #1;
    check("rst_async.dout", dout, '0);
    check("rst_async.busy", {31'd0, busy}, '0);
    @(negedge clk); reset = 1'b1; din_valid = 1'b0; din = '0;

    // ---- Constant table: skew, stall, flush ----
`ifdef DELAY_SKEW_REVERSE_EN
    add(1,0,1,32'h44332211, 32'h44000000, 4'b1000, 1);
    add(1,0,0,32'h0,        32'h0,        4'b0000, 1);
    add(1,0,0,32'h0,        32'h00330000, 4'b0100, 1);
    add(1,0,0,32'h0,        32'h0,        4'b0000, 1);
    add(1,0,0,32'h0,        32'h00002200, 4'b0010, 1);
    add(1,0,0,32'h0,        32'h0,        4'b0000, 1);
    add(1,0,0,32'h0,        32'h00000011, 4'b0001, 1);
    add(1,0,0,32'h0,        32'h0,        4'b0000, 0);
    add(1,0,1,32'h44332211, 32'h44000000, 4'b1000, 1);
    add(1,1,1,32'h55555555, 32'h0,        4'b0000, 0);
    add(1,0,0,32'h0,        32'h0,        4'b0000, 0);
`else
    add(1,0,1,32'h44332211, 32'h00000011, 4'b0001, 1);
    add(1,0,0,32'h0,        32'h00002200, 4'b0010, 1);
    add(1,0,0,32'h0,        32'h00330000, 4'b0100, 1);
    add(1,0,0,32'h0,        32'h44000000, 4'b1000, 1);
    add(1,0,0,32'h0,        32'h0,        4'b0000, 0);
    add(1,0,1,32'h44332211, 32'h00000011, 4'b0001, 1);
    add(1,0,0,32'h0,        32'h00002200, 4'b0010, 1);
    add(0,0,1,32'h99999999, 32'h00002200, 4'b0010, 1);
    add(0,0,0,32'h0,        32'h00002200, 4'b0010, 1);
    add(0,0,1,32'h77777777, 32'h00002200, 4'b0010, 1);
    add(1,0,0,32'h0,        32'h00330000, 4'b0100, 1);
    add(1,0,0,32'h0,        32'h44000000, 4'b1000, 1);
    add(1,0,0,32'h0,        32'h0,        4'b0000, 0);
    add(1,0,1,32'h04030201, 32'h00000001, 4'b0001, 1);
    add(1,0,1,32'h08070605, 32'h00000205, 4'b0011, 1);
    add(1,1,1,32'h0C0B0A09, 32'h0,        4'b0000, 0);
    add(1,0,0,32'h0,        32'h0,        4'b0000, 0);
    add(1,0,0,32'h0,        32'h0,        4'b0000, 0);
    add(1,0,0,32'h0,        32'h0,        4'b0000, 0);
    add(1,0,1,32'h11111111, 32'h00000011, 4'b0001, 1);
    add(0,1,0,32'h0,        32'h0,        4'b0000, 0);
    add(1,0,0,32'h0,        32'h0,        4'b0000, 0);
`endif
    hist = {};
    foreach (tbl[i]) begin
      en = tbl[i].en; flush = tbl[i].flush; din_valid = tbl[i].v; din = tbl[i].din;
      tick();
      check($sformatf("tbl%0d.dout", i), dout, tbl[i].exp_d);
      check($sformatf("tbl%0d.valid", i), {28'd0, dout_valid}, {28'd0, tbl[i].exp_v});
      check($sformatf("tbl%0d.busy", i), {31'd0, busy}, {31'd0, tbl[i].exp_b});
    end
    flush = 1'b0;

    // ---- Invalid bubbles: alternating valid with constant data ----
    en = 1'b1; din = 32'hAAAA_AAAA;
    for (int i = 0; i < 2 * MAXD + 4; i++) begin
      din_valid = i[0] ? 1'b0 : 1'b1;
      tick();
      check_model("bubble");
    end

    // ---- Random traffic with stalls and flushes ----
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      din_valid = ($urandom_range(0, 9) < 6);
      din       = $urandom;
      tick();
      check_model("random");
    end
    en = 1'b1; flush = 1'b0; din_valid = 1'b0;
    for (int i = 0; i < MAXD + 1; i++) begin
      tick();
      check_model("drain");
    end
    check("drain.busy", {31'd0, busy}, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
